// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions for the encoder (pack_i32) and decoder (unpack_i32) sides.
package leb128_pkg;

  typedef enum logic [0:0] {IDLE, EMIT} leb128_state_e;

  localparam int LEB128_MAX_BYTES = 5;
  localparam int LEB128_CONT_BIT  = 7;
  localparam int LEB128_GROUP_W   = 7;

  // Minimal signed LEB128 byte count of a 32-bit word: one byte plus one per
  // 7-bit group boundary the value does not fit below.
  function automatic logic [2:0] leb128_len32(input logic [31:0] v);
    logic [2:0]         n;
    logic signed [31:0] t;
    n = 3'd1;
    for (int k = 1; k < LEB128_MAX_BYTES; k++) begin
      t = $signed(v) >>> (LEB128_GROUP_W * k - 1);
      if (t != '0 && t != '1) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pack_i32_if.sv
// Word-in / byte-out stream bundle for pack_i32.
// Optional len signal present only with PACK_I32_LEN_EN.
interface pack_i32_if;

  logic [31:0] i;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  o;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;
`ifdef PACK_I32_LEN_EN
  logic [2:0]  len;
`endif

  // Encoder side
  modport slave (
    input  i, i_valid, o_ready,
`ifdef PACK_I32_LEN_EN
    output len,
`endif
    output i_ready, o, o_valid, o_last
  );

  // Producer/consumer side
  modport master (
    output i, i_valid, o_ready,
`ifdef PACK_I32_LEN_EN
    input  len,
`endif
    input  i_ready, o, o_valid, o_last
  );

endinterface

// File: rtl/leb128_enc_step.sv
// One signed LEB128 encode step: low group plus continuation bit, the shifted
// remainder, and whether this group ends the encoding. Width-generic.
module leb128_enc_step
  import leb128_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] sr_i,
  output logic [7:0]       byte_o,
  output logic [Width-1:0] rest_o,
  output logic             fin_o
);

  logic [LEB128_GROUP_W-1:0] g;

  // Done once the remainder is pure sign extension of the group's top bit.
  always_comb begin
    g      = sr_i[LEB128_GROUP_W-1:0];
    rest_o = $signed(sr_i) >>> LEB128_GROUP_W;
    fin_o  = (rest_o == '0 && !g[LEB128_GROUP_W-1]) ||
             (rest_o == '1 &&  g[LEB128_GROUP_W-1]);
    byte_o = {~fin_o, g};
  end

endmodule

// File: rtl/pack_i32.sv
// Byte-serial signed LEB128 encoder for 32-bit words.
// Optional feature macro: PACK_I32_LEN_EN adds the len output.
module pack_i32
  import leb128_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  pack_i32_if.slave   bus
);

  leb128_state_e state_q, state_d;
  logic [31:0]   sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    enc_byte;
  logic [31:0]   enc_rest;
  logic          enc_fin;
  logic          o_fire;
  logic          i_fire;

  leb128_enc_step #(
    .Width (32)
  ) u_step (
    .sr_i   (sr_q),
    .byte_o (enc_byte),
    .rest_o (enc_rest),
    .fin_o  (enc_fin)
  );

  // Handshake outputs; i_ready combinationally follows o_ready on the last byte.
  always_comb begin
    bus.o       = enc_byte;
    bus.o_last  = enc_fin;
    bus.o_valid = (state_q == EMIT);
    o_fire      = bus.o_valid && bus.o_ready;
    bus.i_ready = (state_q == IDLE) || (o_fire && enc_fin);
    i_fire      = bus.i_valid && bus.i_ready;
  end

  // Next state: shift out a group per accepted byte, reload on word transfer.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (o_fire) begin
      if (!enc_fin) begin
        sr_d  = enc_rest;
        cnt_d = cnt_q + 3'd1;
      end else begin
        state_d = IDLE;
      end
    end
    if (i_fire) begin
      sr_d    = bus.i;
      cnt_d   = 3'd0;
      state_d = EMIT;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PACK_I32_LEN_EN
  logic [2:0] len_q;

  // Length is computed from the incoming word and held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else if (i_fire) begin
      len_q <= leb128_len32(bus.i);
    end
  end

  // Drive the optional length output.
  always_comb begin
    bus.len = len_q;
  end
`endif

endmodule

// File: tb/tb_pack_i32.sv
// Directed self-checking bench for pack_i32.
module tb_pack_i32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pack_i32_if bus ();

  pack_i32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_len(input string tag, input logic [2:0] exp);
`ifdef PACK_I32_LEN_EN
    chk(tag, {29'd0, bus.len}, {29'd0, exp});
`endif
  endtask

  // Load one word from idle and check its byte stream with o_ready held high.
  // Byte k of the expected stream is eb[8k +: 8].
  task automatic send(input string tag, input logic [31:0] v, input int nb,
                      input logic [39:0] eb, input logic [2:0] el);
    bus.i       = v;
    bus.i_valid = 1'b1;
    bus.o_ready = 1'b1;
    #1;
    chk({tag, "_iready_idle"}, {31'd0, bus.i_ready}, 32'd1);
    step();
    bus.i_valid = 1'b0;
    bus.i       = 32'hdead_beef;
    #1;
    for (int k = 0; k < nb; k++) begin
      chk({tag, "_ovalid"}, {31'd0, bus.o_valid}, 32'd1);
      chk({tag, "_byte"}, {24'd0, bus.o}, {24'd0, eb[8*k +: 8]});
      chk({tag, "_olast"}, {31'd0, bus.o_last}, {31'd0, (k == nb - 1)});
      chk({tag, "_iready"}, {31'd0, bus.i_ready}, {31'd0, (k == nb - 1)});
      chk_len({tag, "_len"}, el);
      step();
    end
    chk({tag, "_idle"}, {31'd0, bus.o_valid}, 32'd0);
  endtask

  logic [7:0]  bp_exp [3];
  logic [7:0]  prev_o;
  logic        prev_rdy;
  int          got;

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.i       = '0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    #2;
    // Reset state
    chk("rst_ovalid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_iready", {31'd0, bus.i_ready}, 32'd1);
    chk("rst_o", {24'd0, bus.o}, 32'h00);
    chk("rst_olast", {31'd0, bus.o_last}, 32'd1);
    chk_len("rst_len", 3'd0);
    step();
    rst_n = 1'b1;
    step();

    send("zero",   32'd0,          1, 40'h00_0000_0000, 3'd1);
    send("m624485", 32'hfff6_789b, 3, 40'h00_0059_f19b, 3'd3);
    send("p63",    32'd63,         1, 40'h00_0000_003f, 3'd1);
    send("p64",    32'd64,         2, 40'h00_0000_00c0, 3'd2);
    send("m64",    32'hffff_ffc0,  1, 40'h00_0000_0040, 3'd1);
    send("m65",    32'hffff_ffbf,  2, 40'h00_0000_7fbf, 3'd2);
    send("max",    32'h7fff_ffff,  5, 40'h07_ffff_ffff, 3'd5);
    send("min",    32'h8000_0000,  5, 40'h78_8080_8080, 3'd5);

    // Back-to-back 0, -1, 64: four bytes over four cycles, no bubble.
    bus.o_ready = 1'b1;
    bus.i       = 32'd0;
    bus.i_valid = 1'b1;
    step();
    bus.i = 32'hffff_ffff;
    #1;
    chk("b2b_0", {24'd0, bus.o}, 32'h00);
    chk("b2b_0_iready", {31'd0, bus.i_ready}, 32'd1);
    step();
    bus.i = 32'd64;
    #1;
    chk("b2b_1", {24'd0, bus.o}, 32'h7f);
    chk("b2b_1_ovalid", {31'd0, bus.o_valid}, 32'd1);
    step();
    bus.i_valid = 1'b0;
    #1;
    chk("b2b_2", {24'd0, bus.o}, 32'hc0);
    chk("b2b_2_olast", {31'd0, bus.o_last}, 32'd0);
    chk("b2b_2_iready", {31'd0, bus.i_ready}, 32'd0);
    step();
    chk("b2b_3", {24'd0, bus.o}, 32'h00);
    chk("b2b_3_olast", {31'd0, bus.o_last}, 32'd1);
    chk("b2b_3_ovalid", {31'd0, bus.o_valid}, 32'd1);
    step();
    chk("b2b_done", {31'd0, bus.o_valid}, 32'd0);

    // Backpressure on -624485 with pseudo-random o_ready.
    bp_exp[0]   = 8'h9b;
    bp_exp[1]   = 8'hf1;
    bp_exp[2]   = 8'h59;
    bus.i       = 32'hfff6_789b;
    bus.i_valid = 1'b1;
    bus.o_ready = 1'b0;
    step();
    bus.i_valid = 1'b0;
    got         = 0;
    prev_o      = 8'h00;
    prev_rdy    = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      bus.o_ready = (cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("bp_ovalid", {31'd0, bus.o_valid}, 32'd1);
      if (!prev_rdy) chk("bp_stable", {24'd0, bus.o}, {24'd0, prev_o});
      if (bus.o_ready) begin
        chk("bp_byte", {24'd0, bus.o}, {24'd0, bp_exp[got]});
        chk("bp_olast", {31'd0, bus.o_last}, {31'd0, (got == 2)});
        got++;
      end
      prev_o   = bus.o;
      prev_rdy = bus.o_ready;
      step();
    end
    chk("bp_count", got, 32'd3);
    chk("bp_idle", {31'd0, bus.o_valid}, 32'd0);

    // Reset mid-word after the first byte has been taken.
    bus.o_ready = 1'b1;
    bus.i       = 32'hfff6_789b;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    #1;
    chk("rm_first", {24'd0, bus.o}, 32'h9b);
    step();
    chk("rm_second", {24'd0, bus.o}, 32'hf1);
    rst_n = 1'b0;
    #1;
    chk("rm_ovalid", {31'd0, bus.o_valid}, 32'd0);
    chk("rm_iready", {31'd0, bus.i_ready}, 32'd1);
    chk_len("rm_len", 3'd0);
    step();
    rst_n = 1'b1;
    step();
    send("five", 32'd5, 1, 40'h00_0000_0005, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pack_i32.md
# pack_i32

Byte-serial signed LEB128 encoder for 32-bit integers, the transmit-side counterpart of the `unpack_i32` decoder. It accepts one 32-bit two's-complement word over a valid/ready handshake and emits its minimal signed LEB128 encoding, 1 to 5 bytes, one byte per cycle, on a second valid/ready stream. It sits between a word producer (ALU, register file, test driver) and a byte-wide output channel, FIFO or serializer.

## Interface

Parameters:
- none. Width is fixed at 32 and the maximum encoding length at 5 bytes.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `i` input 32: signed value to encode.
- `i_valid` input 1: `i` is valid.
- `i_ready` output 1: encoder can accept `i` this cycle.
- `o` output 8: encoded byte; bit 7 is the continuation bit.
- `o_valid` output 1: `o` is valid.
- `o_ready` input 1: sink accepts `o` this cycle.
- `o_last` output 1: the current byte is the final byte of the word, so `o[7]` is 0.
- `len` output 3: total byte count 1..5 for the word in flight. This port exists only with `PACK_I32_LEN_EN`.

## Operation

- States: `IDLE` and `EMIT`.
- Registers:
  - `sr`: 32-bit value register with arithmetic right shift.
  - `cnt`: 3-bit count of bytes already emitted.
  - `len_q`: stored length, present only with `PACK_I32_LEN_EN`.
- Input transfer:
  - A word transfers when `i_valid && i_ready`.
  - On transfer: `sr <= i`, `cnt <= 0`, state goes to `EMIT`.
- Byte computation, purely combinational from `sr`:
  - `g = sr[6:0]`.
  - `rest = sr >>> 7` (arithmetic shift).
  - `fin = (rest == 0 && !g[6]) || (rest == -1 && g[6])`.
  - `o = {~fin, g}`.
  - `o_last = fin`.
- Output transfer:
  - A byte transfers when `o_valid && o_ready`.
  - If `fin` is 0: `sr <= rest`, `cnt <= cnt+1`.
  - If `fin` is 1: the word completes.
- Word completion:
  - If `i_valid` is high in the same cycle, the next word loads and the state stays `EMIT`.
  - Otherwise the state goes to `IDLE`.
- Signals by state:
  - `o_valid = (state == EMIT)`.
  - `i_ready = (state == IDLE) || (o_valid && o_ready && o_last)`. The path from `o_ready` to `i_ready` is combinational by design.
- `fin` is guaranteed true when `cnt == 4`. Sign-extension makes bits 31:28 of the fifth group consistent. `cnt` never exceeds 4, so no overflow handling is needed.
- Backpressure: while `o_valid && !o_ready`, the outputs `o`, `o_last` and `len` hold stable and `sr`/`cnt` do not change.
- Encoding is always minimal and bit-exact with what `unpack_i32` decodes, including its reported `len`.

## Timing

- Reset values:
  - `state = IDLE`, `sr = 0`, `cnt = 0`, `len_q = 0`.
  - Outputs: `o_valid = 0`, `i_ready = 1`, `o = 8'h00`, `o_last = 1`, `len = 0`.
- Latency: the first byte is valid in the cycle after the input transfer.
- Throughput: one byte per cycle with `o_ready` held high.
  - Back-to-back words have no bubble: an N-byte word occupies exactly N cycles.
- Reset asserted mid-word: the word is discarded immediately (asynchronously) and no partial completion occurs. After release, the next byte seen is the first byte of a new word.
- `i_valid` may rise or fall freely. `i` is sampled only on a transfer.
- Asserting `o_valid` does not depend on `o_ready`.

## Configuration

- `PACK_I32_LEN_EN` defined:
  - Adds the `len` output.
  - On input transfer, `len_q` is loaded with the precomputed byte count of `i`. The count is 1 + the number of 7-bit group boundaries below the minimal sign-extended width, computed combinationally from `i`.
  - `len` equals `len_q` throughout `EMIT` and holds its last value in `IDLE`.
- `PACK_I32_LEN_EN` undefined:
  - No `len` port and no length logic.
  - Byte sequence and timing are identical.

## Structure

- Package `leb128_pkg`:
  - State enum `{IDLE, EMIT}`.
  - `LEB128_MAX_BYTES = 5`.
  - `LEB128_CONT_BIT = 7`.
  - `LEB128_GROUP_W = 7`.
  - This package is shared with the decoder side.
- Sub-module `leb128_enc_step`: combinational, taking `sr` and producing `o`, `rest` and `fin`. It is reusable for a future 64-bit variant.
- Top level: FSM, registers, handshake and optional length counter.

## Test plan

- `i=0`, `o_ready=1` → a single byte `8'h00`, `o_last=1`, `len=1`; `i_ready` is high again in the same cycle.
- `i=-624485` → bytes `9b`, `f1`, `59` on 3 consecutive cycles; `o_last` only on `59`; `len=3`.
- Sign boundaries:
  - 63 → `3f`.
  - 64 → `c0 00`.
  - -64 → `40`.
  - -65 → `bf 7f`.
- Extremes:
  - `32'h7fffffff` → `ff ff ff ff 07`.
  - `32'h80000000` → `80 80 80 80 78`.
  - Both have `len=5`.
- Back-to-back 0, -1, 64 with `o_ready=1` → stream `00`, `7f`, `c0`, `00` over 4 cycles with no bubble.
- Backpressure and reset:
  - Random `o_ready` toggling on `-624485` → identical byte stream, with `o` stable during stalls.
  - `rst_n` pulsed low after the first byte → `o_valid=0` and `i_ready=1` immediately.
  - Next word `5` → `05`.
